cr_prefix_obc: RTL
==================

CR_PREFIX_OBC -- requirements
Module: cr_prefix_obc

Interface
REQ-001 Parameter: OBC_PFD_TIMEOUT, default 8'd255, consecutive starved cycles in INSERT before abort.
REQ-002 clk  input  1  sole clock; all state rises on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 bp_tlv_empty  input  1  bypass TLV FIFO empty.
REQ-005 bp_tlv  input  tlvp_if_bus_t  bypass TLV FIFO head word.
REQ-006 bp_tlv_rd  output  1  bypass FIFO pop, combinational.
REQ-007 pfd_tlv_empty  input  1  generated prefix-data (PFD) TLV FIFO empty.
REQ-008 pfd_tlv  input  tlvp_if_bus_t  PFD FIFO head word.
REQ-009 pfd_tlv_rd  output  1  PFD FIFO pop, combinational.
REQ-010 usr_ob_full  input  1  user output FIFO full.
REQ-011 usr_ob_afull  input  1  user output FIFO almost full.
REQ-012 usr_ob_wr  output  1  user output write strobe, registered.
REQ-013 usr_ob_tlv  output  tlvp_if_bus_t  user output word, registered.
REQ-014 obc_pfd_done  output  1  one-cycle pulse, PFD TLV fully forwarded.
REQ-015 obc_err  output  1  one-cycle pulse, PFD protocol error or timeout.

Function
REQ-016 stall = usr_ob_full | (usr_ob_afull & usr_ob_wr).
REQ-017 FSM states: PASS, INSERT; PASS after reset.
REQ-018 PASS: bp_tlv_rd = ~bp_tlv_empty & ~stall; pfd_tlv_rd = 0, even when PFD is non-empty.
REQ-019 INSERT: pfd_tlv_rd = ~pfd_tlv_empty & ~stall; bp_tlv_rd = 0, even when bypass is non-empty.
REQ-020 Latency: the word popped in cycle N appears on usr_ob_tlv with usr_ob_wr=1 in cycle N+1.
REQ-021 No pop in a cycle: usr_ob_wr=0 next cycle and usr_ob_tlv is held.
REQ-022 Insert decision: bypass word popped with typen==CMD and eot is cast to tlv_cmd_word_2_t.
REQ-023 That word sets insert when xp10_user_prefix_size==0 and xp10_prefix_mode is PREDET_HUFF or PREDEF_PREFIX.
REQ-024 insert true -> PASS->INSERT on the next cycle; otherwise remain in PASS.
REQ-025 INSERT->PASS on the cycle after the PFD word with eot is popped; obc_pfd_done=1 in that same cycle.
REQ-026 First PFD word popped in an INSERT visit without sot -> obc_err pulse next cycle; word still forwarded.
REQ-027 8-bit starve counter: clears on entry to INSERT and on every PFD pop.
REQ-028 Starve counter increments when INSERT & pfd_tlv_empty & ~stall; holds while stalled.
REQ-029 Starve counter reaching OBC_PFD_TIMEOUT -> obc_err pulse, return to PASS next cycle, counter cleared.
REQ-030 On timeout, no obc_pfd_done and no synthetic eot word.
REQ-031 The same bypass word is never popped twice; a word is never dropped while stall=1 (no pop occurs).
REQ-032 usr_ob_full=1 in INSERT with pfd eot at head -> no pop, no transition until full clears.

Reset
REQ-033 rst=1 -> state PASS, counters 0, usr_ob_tlv=0, usr_ob_wr=0, obc_pfd_done=0, obc_err=0, insert flag 0.
REQ-034 Reset mid-INSERT or mid-TLV abandons the partial TLV; no completion word is emitted after reset release.
REQ-035 Popping restarts the first cycle rst is low.

Structure
REQ-036 The state enum (PASS/INSERT) and the OBC_PFD_TIMEOUT default live in cr_prefixPKG.
REQ-037 tlvp_if_bus_t and tlv_cmd_word_2_t come from cr_structs.sv.
REQ-038 Single flat module; no sub-module is warranted.

Verification
REQ-039 Scenario 1 stimulus: CMD TLV (prefix_size=0, PREDEF_PREFIX), then 4-word PFD TLV, then 3 DATA_UNK words on bypass.
REQ-040 Scenario 1 response: output order CMD, PFD x4, DATA x3; obc_pfd_done pulses once.
REQ-041 Scenario 2 stimulus: CMD with xp10_user_prefix_size=5, PFD FIFO non-empty.
REQ-042 Scenario 2 response: pfd_tlv_rd never asserts; bypass forwarded unchanged, 1-cycle latency.
REQ-043 Scenario 3 stimulus: usr_ob_afull=1 during a back-to-back stream.
REQ-044 Scenario 3 response: writes alternate 1,0,1,0; usr_ob_full=1 -> zero pops; no loss or duplication.
REQ-045 Scenario 4 stimulus: INSERT with PFD FIFO empty for 255 cycles.
REQ-046 Scenario 4 response: obc_err pulses exactly once at cycle 255; bypass resumes the next cycle.
REQ-047 Scenario 5 stimulus: first PFD word has sot=0.
REQ-048 Scenario 5 response: obc_err pulses; word is forwarded; done still pulses at eot.
REQ-049 Scenario 6 stimulus: rst asserted mid-INSERT after 2 of 4 PFD words.
REQ-050 Scenario 6 response: all outputs 0 immediately; state PASS after release.

Source files
------------

// File: rtl/cr_prefixPKG.sv
// Local types and defaults for the prefix output controller.
// Pure definitions; no latency.
// No flow control.
package cr_prefixPKG;

    // Controller phases: forward bypass traffic, or splice in the PFD TLV
    typedef enum logic {
        PASS   = 1'b0,
        INSERT = 1'b1
    } obc_state_e;

    // Starved INSERT cycles tolerated before the PFD insertion is abandoned
    localparam logic [7:0] OBC_PFD_TIMEOUT_DFLT = 8'd255;

endpackage

// File: rtl/cr_structs.sv
// Shared TLV bus and command-word layouts used by the prefix output path.
// Pure type definitions; no logic, no latency.
// No flow control here; users carry their own rd/wr/full handshakes.
package cr_structs;

    // TLV type codes carried in every bus word
    typedef enum logic [4:0] {
        DATA_UNK = 5'd0,
        CMD      = 5'd1,
        PFD      = 5'd2,
        FTR      = 5'd3
    } tlv_types_e;

    // One word of the TLV pipe bus (header bits on top, payload below)
    typedef struct packed {
        tlv_types_e  typen;
        logic        sot;
        logic        eot;
        logic [7:0]  tuser;
        logic [63:0] tdata;
    } tlvp_if_bus_t;

    // Prefix handling requested by the command TLV
    typedef enum logic [3:0] {
        NO_PREFIX     = 4'd0,
        USER_PREFIX   = 4'd1,
        PREDEF_PREFIX = 4'd2,
        PREDET_HUFF   = 4'd3
    } xp10_prefix_mode_e;

    // Overlay of the final command word; same width as tlvp_if_bus_t
    typedef struct packed {
        logic [14:0]       tlv_hdr;
        logic [37:0]       rsvd0;
        logic [5:0]        xp10_user_prefix_size;
        xp10_prefix_mode_e xp10_prefix_mode;
        logic [15:0]       rsvd1;
    } tlv_cmd_word_2_t;

endpackage

// File: rtl/cr_prefix_obc.sv
// Merges the bypass TLV stream with a generated prefix-data TLV after qualifying commands.
// Latency: a word popped in cycle N is written to the user FIFO in cycle N+1.
// Backpressure: no pop while the user FIFO is full, or almost full with a write in flight.
module cr_prefix_obc
    import cr_structs::*;
    import cr_prefixPKG::*;
#(
    parameter logic [7:0] OBC_PFD_TIMEOUT = OBC_PFD_TIMEOUT_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bp_tlv_empty,
    input  tlvp_if_bus_t bp_tlv,
    output logic         bp_tlv_rd,
    input  logic         pfd_tlv_empty,
    input  tlvp_if_bus_t pfd_tlv,
    output logic         pfd_tlv_rd,
    input  logic         usr_ob_full,
    input  logic         usr_ob_afull,
    output logic         usr_ob_wr,
    output tlvp_if_bus_t usr_ob_tlv,
    output logic         obc_pfd_done,
    output logic         obc_err
);

    obc_state_e      state_q, state_nxt;
    logic [7:0]      starve_q, starve_nxt;
    logic [7:0]      starve_inc;
    logic            pfd_first_q, pfd_first_nxt;
    logic            done_nxt, err_nxt, wr_nxt;
    tlvp_if_bus_t    tlv_nxt;
    logic            stall;
    logic            insert_hit;
    tlv_cmd_word_2_t cmd_w;
    logic            cmd_unused;

    // Almost-full only bites when a write is already landing this cycle
    assign stall = usr_ob_full | (usr_ob_afull & usr_ob_wr);

    // The last command word carries the prefix request fields
    assign cmd_w      = tlv_cmd_word_2_t'(bp_tlv);
    assign cmd_unused = ^{cmd_w.tlv_hdr, cmd_w.rsvd0, cmd_w.rsvd1};

    // A qualifying command asks for generated prefix data to follow it
    assign insert_hit = bp_tlv_rd && (bp_tlv.typen == CMD) && bp_tlv.eot &&
                        (cmd_w.xp10_user_prefix_size == 6'd0) &&
                        ((cmd_w.xp10_prefix_mode == PREDET_HUFF) ||
                         (cmd_w.xp10_prefix_mode == PREDEF_PREFIX));

    assign starve_inc = starve_q + 8'd1;

    // Pop only the FIFO that owns the current phase, and never during reset
    always_comb begin
        bp_tlv_rd  = 1'b0;
        pfd_tlv_rd = 1'b0;
        if (!rst) begin
            if (state_q == PASS) begin
                bp_tlv_rd = ~bp_tlv_empty & ~stall;
            end else begin
                pfd_tlv_rd = ~pfd_tlv_empty & ~stall;
            end
        end
    end

    // Phase transitions, starvation watchdog and registered output staging
    always_comb begin
        state_nxt     = state_q;
        starve_nxt    = starve_q;
        pfd_first_nxt = pfd_first_q;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        wr_nxt        = bp_tlv_rd | pfd_tlv_rd;
        tlv_nxt       = usr_ob_tlv;
        if (bp_tlv_rd) begin
            tlv_nxt = bp_tlv;
        end else if (pfd_tlv_rd) begin
            tlv_nxt = pfd_tlv;
        end

        case (state_q)
            PASS: begin
                if (insert_hit) begin
                    state_nxt     = INSERT;
                    starve_nxt    = 8'd0;
                    pfd_first_nxt = 1'b1;
                end
            end
            INSERT: begin
                if (pfd_tlv_rd) begin
                    starve_nxt    = 8'd0;
                    pfd_first_nxt = 1'b0;
                    // A PFD TLV that does not open with sot is malformed, but still forwarded
                    if (pfd_first_q && !pfd_tlv.sot) begin
                        err_nxt = 1'b1;
                    end
                    if (pfd_tlv.eot) begin
                        state_nxt = PASS;
                        done_nxt  = 1'b1;
                    end
                end else if (pfd_tlv_empty && !stall) begin
                    // Give up on the generator; no synthetic eot is fabricated
                    if (starve_inc == OBC_PFD_TIMEOUT) begin
                        err_nxt       = 1'b1;
                        state_nxt     = PASS;
                        starve_nxt    = 8'd0;
                        pfd_first_nxt = 1'b0;
                    end else begin
                        starve_nxt = starve_inc;
                    end
                end
            end
            default: begin
                state_nxt = PASS;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial TLV
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PASS;
            starve_q     <= 8'd0;
            pfd_first_q  <= 1'b0;
            usr_ob_wr    <= 1'b0;
            usr_ob_tlv   <= '0;
            obc_pfd_done <= 1'b0;
            obc_err      <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            starve_q     <= starve_nxt;
            pfd_first_q  <= pfd_first_nxt;
            usr_ob_wr    <= wr_nxt;
            usr_ob_tlv   <= tlv_nxt;
            obc_pfd_done <= done_nxt;
            obc_err      <= err_nxt;
        end
    end

endmodule
